// File: rtl/rally_ctrl.sv
// Pong match sequencer: start, serve delay, play, goal scoring, game-over hold.
// Every output is a register; the next values come from a single combinational FSM block.
module rally_ctrl #(
    parameter int MAX_SCORE          = 9,
    parameter int M_SCORE_W          = 4,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int OVER_HOLD_FRAMES   = 180
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 frame_tick_i,
    input  logic                 start_i,
    input  logic                 p_goal_i,
    input  logic                 e_goal_i,
    output logic                 ball_rst_o,
    output logic                 ball_en_o,
    output logic                 serve_dir_o,
    output logic [M_SCORE_W-1:0] p_score_o,
    output logic [M_SCORE_W-1:0] e_score_o,
    output logic                 game_over_o,
    output logic                 winner_o
);
    localparam int CNT_MAX = (SERVE_DELAY_FRAMES > OVER_HOLD_FRAMES) ?
                             SERVE_DELAY_FRAMES : OVER_HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]     SERVE_LOAD = CNT_W'(SERVE_DELAY_FRAMES);
    localparam logic [CNT_W-1:0]     HOLD_LOAD  = CNT_W'(OVER_HOLD_FRAMES);
    localparam logic [M_SCORE_W-1:0] WIN_SCORE  = M_SCORE_W'(MAX_SCORE);

    typedef enum logic [2:0] {IDLE, SERVE_WAIT, PLAY, OVER_HOLD, OVER_WAIT} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [M_SCORE_W-1:0] p_nxt, e_nxt, p_inc, e_inc;
    logic                 ball_rst_nxt, ball_en_nxt, dir_nxt, over_nxt, win_nxt;

    assign p_inc = p_score_o + 1'b1;
    assign e_inc = e_score_o + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            ball_rst_o  <= 1'b0;
            ball_en_o   <= 1'b0;
            serve_dir_o <= 1'b0;
            p_score_o   <= '0;
            e_score_o   <= '0;
            game_over_o <= 1'b0;
            winner_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ball_rst_o  <= ball_rst_nxt;
            ball_en_o   <= ball_en_nxt;
            serve_dir_o <= dir_nxt;
            p_score_o   <= p_nxt;
            e_score_o   <= e_nxt;
            game_over_o <= over_nxt;
            winner_o    <= win_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        p_nxt        = p_score_o;
        e_nxt        = e_score_o;
        dir_nxt      = serve_dir_o;
        over_nxt     = game_over_o;
        win_nxt      = winner_o;
        ball_rst_nxt = 1'b0;
        case (state)
            IDLE, OVER_WAIT: begin
                if (start_i) begin
                    state_nxt    = SERVE_WAIT;
                    cnt_nxt      = SERVE_LOAD;
                    p_nxt        = '0;
                    e_nxt        = '0;
                    dir_nxt      = 1'b1;
                    over_nxt     = 1'b0;
                    win_nxt      = 1'b0;
                    ball_rst_nxt = 1'b1;
                end
            end
            SERVE_WAIT: begin
                if (frame_tick_i) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = PLAY;
                end
            end
            PLAY: begin
                // p_goal_i has priority; a simultaneous e_goal_i is dropped.
                if (p_goal_i || e_goal_i) begin
                    if (p_goal_i) begin
                        p_nxt   = p_inc;
                        dir_nxt = 1'b1;
                    end else begin
                        e_nxt   = e_inc;
                        dir_nxt = 1'b0;
                    end
                    if ((p_goal_i && p_inc == WIN_SCORE) || (!p_goal_i && e_inc == WIN_SCORE)) begin
                        state_nxt = OVER_HOLD;
                        cnt_nxt   = HOLD_LOAD;
                        over_nxt  = 1'b1;
                        win_nxt   = !p_goal_i;
                    end else begin
                        state_nxt    = SERVE_WAIT;
                        cnt_nxt      = SERVE_LOAD;
                        ball_rst_nxt = 1'b1;
                    end
                end
            end
            OVER_HOLD: begin
                if (frame_tick_i) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = OVER_WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ball_en_nxt = (state_nxt == PLAY);
    end
endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl: each step queues its hand-computed outputs,
// a monitor pops and compares them one clock edge later.
module tb_rally_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pg = 1'b0, eg = 1'b0;
    logic       ball_rst, ball_en, serve_dir, game_over, winner;
    logic [3:0] p_score, e_score;

    typedef struct {
        string       name;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    rally_ctrl #(
        .MAX_SCORE(3), .M_SCORE_W(4), .SERVE_DELAY_FRAMES(2), .OVER_HOLD_FRAMES(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(tick), .start_i(start),
        .p_goal_i(pg), .e_goal_i(eg), .ball_rst_o(ball_rst), .ball_en_o(ball_en),
        .serve_dir_o(serve_dir), .p_score_o(p_score), .e_score_o(e_score),
        .game_over_o(game_over), .winner_o(winner)
    );

    always #5 clk = ~clk;

    task automatic compare(input string n, input logic [12:0] e);
        logic [12:0] a;
        a = {ball_rst, ball_en, serve_dir, p_score, e_score, game_over, winner};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got rst=%b en=%b dir=%b p=%0d e=%0d over=%b win=%b, want rst=%b en=%b dir=%b p=%0d e=%0d over=%b win=%b",
                     n, a[12], a[11], a[10], a[9:6], a[5:2], a[1], a[0],
                     e[12], e[11], e[10], e[9:6], e[5:2], e[1], e[0]);
        end
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            compare(x.name, x.v);
        end
    end

    // One cycle of stimulus plus the outputs expected after the next edge.
    task automatic s(input string n, input bit tk, input bit st, input bit p_g, input bit e_g,
                     input bit r, input bit en, input bit d, input int ps, input int es,
                     input bit go, input bit w);
        exp_t x;
        @(negedge clk);
        tick = tk; start = st; pg = p_g; eg = e_g;
        x.name = n;
        x.v = {r, en, d, ps[3:0], es[3:0], go, w};
        q.push_back(x);
    endtask

    task automatic release_reset();
        @(negedge clk);
        tick = 0; start = 0; pg = 0; eg = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //  name          tk st pg eg   rst en dir p  e  go win
        s("reset",        0, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
        release_reset();
        s("idle",         0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // 1: start and serve delay
        s("start",        1, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0);
        s("sw_tick1",     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        s("sw_gap",       0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        s("sw_tick2",     1, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0);
        // 2: player then enemy goal
        s("p_goal",       0, 0, 1, 0,   1, 0, 1, 1, 0, 0, 0);
        s("t_a1",         1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        s("t_a2",         1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 0);
        s("e_goal",       0, 0, 0, 1,   1, 0, 0, 1, 1, 0, 0);
        s("t_b1",         1, 0, 0, 0,   0, 0, 0, 1, 1, 0, 0);
        s("t_b2",         1, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0);
        // 3: simultaneous goals with a tick
        s("both_goals",   1, 0, 1, 1,   1, 0, 1, 2, 1, 0, 0);
        s("t_c1",         1, 0, 0, 0,   0, 0, 1, 2, 1, 0, 0);
        s("t_c2",         1, 0, 0, 0,   0, 1, 1, 2, 1, 0, 0);
        // 5: goals and start ignored while serving
        s("e_goal2",      0, 0, 0, 1,   1, 0, 0, 2, 2, 0, 0);
        s("sw_noise",     0, 1, 1, 1,   0, 0, 0, 2, 2, 0, 0);
        s("sw_noise_t1",  1, 0, 0, 1,   0, 0, 0, 2, 2, 0, 0);
        s("sw_noise_t2",  1, 1, 1, 0,   0, 1, 0, 2, 2, 0, 0);
        // 4: enemy wins, hold, restart
        s("e_win",        0, 0, 0, 1,   0, 0, 0, 2, 3, 1, 1);
        s("hold_start",   0, 1, 0, 0,   0, 0, 0, 2, 3, 1, 1);
        s("hold_t1",      1, 1, 1, 0,   0, 0, 0, 2, 3, 1, 1);
        s("hold_t2",      1, 1, 0, 0,   0, 0, 0, 2, 3, 1, 1);
        s("over_wait",    0, 0, 0, 0,   0, 0, 0, 2, 3, 1, 1);
        s("restart",      0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0);
        // 6: build 2/1 then reset mid-serve
        s("r_t1",         1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        s("r_t2",         1, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0);
        s("r_pg1",        0, 0, 1, 0,   1, 0, 1, 1, 0, 0, 0);
        s("r_t3",         1, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        s("r_t4",         1, 0, 0, 0,   0, 1, 1, 1, 0, 0, 0);
        s("r_pg2",        0, 0, 1, 0,   1, 0, 1, 2, 0, 0, 0);
        s("r_t5",         1, 0, 0, 0,   0, 0, 1, 2, 0, 0, 0);
        s("r_t6",         1, 0, 0, 0,   0, 1, 1, 2, 0, 0, 0);
        s("r_eg",         0, 0, 0, 1,   1, 0, 0, 2, 1, 0, 0);
        s("r_t7",         1, 0, 0, 0,   0, 0, 0, 2, 1, 0, 0);
        @(negedge clk);
        tick = 0; start = 0; pg = 0; eg = 0;
        #2 rst_n = 1'b0;
        #1 compare("async_reset", 13'd0);
        s("in_reset",     1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        release_reset();
        s("idle_no_start",1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        // Start held as a level for a whole match that the player wins.
        s("lvl_start",    0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0);
        s("l_t1",         1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
        s("l_t2",         1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);
        s("l_pg1",        0, 1, 1, 0,   1, 0, 1, 1, 0, 0, 0);
        s("l_t3",         1, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        s("l_t4",         1, 1, 0, 0,   0, 1, 1, 1, 0, 0, 0);
        s("l_pg2",        0, 1, 1, 0,   1, 0, 1, 2, 0, 0, 0);
        s("l_t5",         1, 1, 0, 0,   0, 0, 1, 2, 0, 0, 0);
        s("l_t6",         1, 1, 0, 0,   0, 1, 1, 2, 0, 0, 0);
        s("p_win",        0, 1, 1, 0,   0, 0, 1, 3, 0, 1, 0);
        s("l_hold1",      1, 1, 0, 0,   0, 0, 1, 3, 0, 1, 0);
        s("l_hold2",      1, 1, 0, 0,   0, 0, 1, 3, 0, 1, 0);
        s("l_autostart",  0, 1, 0, 0,   1, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        tick = 0; start = 0; pg = 0; eg = 0;
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
